// File: rtl/dmem_sized.sv
// Sized data memory: byte/half/word loads and stores with a one-cycle registered response.
// A preload sequencer fills every word after reset before requests are accepted.
module dmem_sized #(
   parameter int unsigned DEPTH     = 2048,
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned INIT_MODE = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              init_done
);

   localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {StInit, StRun} state_e;

   state_e            state_q, state_d;
   logic [IdxW-1:0]   cnt_q, cnt_d;
   logic              resp_valid_q;
   logic [31:0]       resp_rdata_q;
   logic              resp_err_q;
   logic [31:0]       mem_q [DEPTH];

   logic [ADDR_W-3:0] widx;
   logic [1:0]        lane;
   logic [IdxW-1:0]   mem_idx;
   logic              accept, size_err, align_err, range_err, req_err, wr_en;
   logic [31:0]       rd_word, sh_b, sh_h, load_val, wr_lanes, init_val;
   logic [3:0]        be;

   assign widx      = req_addr[ADDR_W-1:2];
   assign lane      = req_addr[1:0];
   assign mem_idx   = IdxW'(widx);
   assign range_err = 64'(widx) >= 64'(DEPTH);
   assign req_ready = (state_q == StRun);
   assign init_done = (state_q == StRun);
   assign accept    = req_valid && req_ready;
   assign req_err   = size_err || align_err || range_err;
   assign wr_en     = accept && req_we && !req_err;
   assign init_val  = (INIT_MODE == 1) ? 32'(cnt_q) : 32'd0;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == StInit) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == IdxW'(DEPTH - 1)) begin
            state_d = StRun;
         end
      end
   end

   // Alignment, size legality and the byte-enable/lane replication for stores.
   always_comb begin
      size_err  = 1'b0;
      align_err = 1'b0;
      be        = 4'b0000;
      wr_lanes  = req_wdata;
      case (req_size)
         2'b00: begin
            be       = 4'b0001 << lane;
            wr_lanes = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            align_err = lane[0];
            be        = lane[1] ? 4'b1100 : 4'b0011;
            wr_lanes  = {2{req_wdata[15:0]}};
         end
         2'b10: begin
            align_err = |lane;
            be        = 4'b1111;
         end
         default: size_err = 1'b1;
      endcase
   end

   assign rd_word = mem_q[mem_idx];
   assign sh_b    = rd_word >> {lane, 3'b000};
   assign sh_h    = rd_word >> {lane[1], 4'b0000};

   always_comb begin
      load_val = rd_word;
      case (req_size)
         2'b00:   load_val = req_unsigned ? {24'd0, sh_b[7:0]} : {{24{sh_b[7]}}, sh_b[7:0]};
         2'b01:   load_val = req_unsigned ? {16'd0, sh_h[15:0]} : {{16{sh_h[15]}}, sh_h[15:0]};
         default: load_val = rd_word;
      endcase
   end

   // Memory has no reset; the init sequence rewrites every word after each reset.
   always_ff @(posedge clk) begin
      if (state_q == StInit) begin
         mem_q[cnt_q] <= init_val;
      end else if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
               mem_q[mem_idx][8*b +: 8] <= wr_lanes[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StInit;
         cnt_q        <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'd0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         resp_valid_q <= accept;
         if (accept) begin
            resp_rdata_q <= (req_err || req_we) ? 32'd0 : load_val;
            resp_err_q   <= req_err;
         end
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_sized.sv
// Scoreboard bench for dmem_sized: byte-level reference memory, expected responses queued at
// issue time and popped by an independent monitor whenever resp_valid is seen.
module tb_dmem_sized;
   localparam int unsigned DEPTH  = 2048;
   localparam int unsigned ADDR_W = 32;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_we = 1'b0;
   logic [1:0]        req_size = 2'b10;
   logic              req_unsigned = 1'b0;
   logic [ADDR_W-1:0] req_addr = '0;
   logic [31:0]       req_wdata = '0;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_err;
   logic              init_done;

   always #5 clk = ~clk;

   dmem_sized #(
      .DEPTH(DEPTH),
      .ADDR_W(ADDR_W),
      .INIT_MODE(1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_we(req_we),
      .req_size(req_size),
      .req_unsigned(req_unsigned),
      .req_addr(req_addr),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid),
      .resp_rdata(resp_rdata),
      .resp_err(resp_err),
      .init_done(init_done)
   );

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] ref_mem [DEPTH];
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && resp_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: resp_valid=1 with nothing pending, expected 0");
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("resp_rdata", resp_rdata, e.rdata);
            check("resp_err", 32'(resp_err), 32'(e.err));
         end
      end
   end

   // Byte-granular reference: error rules from size/alignment/range, then copy bytes.
   task automatic model(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic err, output logic [31:0] rd);
      int unsigned wi, lane, nb;
      wi   = addr / 4;
      lane = addr % 4;
      nb   = 1 << size;
      err  = (size == 2'b11) || (addr % nb != 0) || (wi >= DEPTH);
      rd   = 32'd0;
      if (err) return;
      for (int i = 0; i < int'(nb); i++) begin
         if (we) ref_mem[wi][8*(lane+i) +: 8] = wdata[8*i +: 8];
         else    rd[8*i +: 8] = ref_mem[wi][8*(lane+i) +: 8];
      end
      if (!we && !uns && rd[8*nb-1]) begin
         for (int i = int'(nb); i < 4; i++) rd[8*i +: 8] = 8'hFF;
      end
   endtask

   task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic has_k, input logic [31:0] k_rdata, input logic k_err);
      logic        m_err;
      logic [31:0] m_rd;
      exp_t        e;
      @(negedge clk);
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      model(we, size, uns, addr, wdata, m_err, m_rd);
      e.rdata = has_k ? k_rdata : m_rd;
      e.err   = has_k ? k_err : m_err;
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         req_valid = 1'b0;
      end
   endtask

   task automatic reset_and_init(input logic hold_valid);
      int n;
      @(negedge clk);
      rst       = 1'b1;
      req_valid = 1'b0;
      exp_q.delete();
      #1;
      check("rst_ready", 32'(req_ready), 0);
      check("rst_init_done", 32'(init_done), 0);
      check("rst_resp_valid", 32'(resp_valid), 0);
      check("rst_resp_rdata", resp_rdata, 0);
      check("rst_resp_err", 32'(resp_err), 0);
      for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = 32'(i);
      @(negedge clk);
      rst = 1'b0;
      if (hold_valid) begin
         req_valid = 1'b1;
         req_we    = 1'b1;
         req_size  = 2'b10;
         req_addr  = 32'h0;
         req_wdata = 32'hFFFF_FFFF;
      end
      n = 0;
      while (!req_ready && n < int'(DEPTH) + 16) begin
         @(negedge clk);
         n++;
      end
      req_valid = 1'b0;
      check("init_cycles", 32'(n), DEPTH);
      check("init_done", 32'(init_done), 1);
   endtask

   initial begin
      logic [1:0]  sz;
      logic [31:0] a;
      int          r;

      // Requests held valid during INIT must be ignored.
      reset_and_init(1'b1);

      issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b1, 32'h10, 1'b0);
      issue(1'b1, 2'b10, 1'b0, 32'h100, 32'h8899AABB, 1'b1, 32'h0, 1'b0);
      issue(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 1'b1, 32'hFFFFFFAA, 1'b0);
      issue(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 1'b1, 32'h00000088, 1'b0);
      issue(1'b1, 2'b10, 1'b0, 32'h100, 32'h11223344, 1'b1, 32'h0, 1'b0);
      issue(1'b1, 2'b01, 1'b0, 32'h102, 32'h0000F00D, 1'b1, 32'h0, 1'b0);
      issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1, 32'hF00D3344, 1'b0);
      issue(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 1'b1, 32'hFFFFF00D, 1'b0);
      issue(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 1'b1, 32'h0000F00D, 1'b0);
      idle(2);

      issue(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 1'b1, 32'h0, 1'b1);
      issue(1'b1, 2'b01, 1'b0, 32'h201, 32'hFFFF, 1'b1, 32'h0, 1'b1);
      issue(1'b1, 2'b11, 1'b0, 32'h200, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b1);
      issue(1'b0, 2'b10, 1'b0, 4 * DEPTH, 32'h0, 1'b1, 32'h0, 1'b1);
      issue(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 1'b1, 32'h00000080, 1'b0);
      issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1, 32'hF00D3344, 1'b0);
      idle(2);

      issue(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0);
      issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);
      idle(2);

      // Ten back-to-back requests: the previous response must be visible at every issue edge.
      for (int i = 0; i < 10; i++) begin
         issue(i[0], 2'b10, 1'b0, 32'h40 + 32'(4 * i), 32'hA5A50000 + 32'(i), 1'b0, 32'h0, 1'b0);
         if (i > 0) check("burst_resp_valid", 32'(resp_valid), 1);
      end
      @(negedge clk);
      req_valid = 1'b0;
      check("burst_last_valid", 32'(resp_valid), 1);
      idle(2);

      for (int i = 0; i < 400; i++) begin
         r  = $urandom_range(0, 9);
         sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         if (r == 0)      a = 4 * DEPTH + $urandom_range(0, 63);
         else if (r == 1) a = 4 * DEPTH - 64 + $urandom_range(0, 63);
         else             a = $urandom_range(0, 127);
         if ($urandom_range(0, 1) == 1 && sz != 2'b11) a = a & ~((32'd1 << sz) - 1);
         issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, 1'b0,
               32'h0, 1'b0);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
      idle(3);
      check("queue_drained", 32'(exp_q.size()), 0);

      // Reset right after a load is accepted: its response must never appear.
      issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      exp_q.delete();
      #1;
      check("run_rst_resp_valid", 32'(resp_valid), 0);
      reset_and_init(1'b0);
      issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1, 32'h00000008, 1'b0);
      issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678, 1'b1, 32'h0, 1'b0);
      idle(2);

      // Reset in the middle of INIT restarts the full preload.
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      idle(500);
      check("mid_init_ready", 32'(req_ready), 0);
      reset_and_init(1'b0);
      issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1, 32'h00000008, 1'b0);
      issue(1'b0, 2'b10, 1'b0, 4 * (DEPTH - 1), 32'h0, 1'b1, DEPTH - 1, 1'b0);
      idle(3);
      check("final_drained", 32'(exp_q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
